// File: rtl/hssl_cfg_pkt_rx.sv
// hssl_cfg_pkt_rx: splits incoming packets into register-bank writes
// (config packets) and a 2-entry in-order forward FIFO (everything else).
// Config writes bypass the FIFO, so they may overtake buffered forward packets.
module hssl_cfg_pkt_rx #(
  parameter int          RADDR_BITS = 8,
  parameter logic [31:0] CFG_KEY    = 32'hffff_fe00,
  parameter logic [31:0] CFG_MSK    = 32'hffff_ff00
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           pkt_key_in,
  input  logic [31:0]           pkt_data_in,
  input  logic                  pkt_pld_in,
  input  logic                  pkt_vld_in,
  output logic                  pkt_rdy_out,
  output logic [31:0]           out_key_out,
  output logic [31:0]           out_data_out,
  output logic                  out_pld_out,
  output logic                  out_vld_out,
  input  logic                  out_rdy_in,
  output logic [RADDR_BITS-1:0] prx_addr_out,
  output logic [31:0]           prx_wdata_out,
  output logic                  prx_en_out,
  output logic                  cfg_cnt_out,
  output logic                  err_cnt_out
);

  // forward FIFO storage and pointers
  logic [31:0]           r_ent_key  [2];
  logic [31:0]           r_ent_data [2];
  logic                  r_ent_pld  [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  logic                  r_rdy;

  // register-bank write port and diagnostic pulses
  logic                  r_prx_en;
  logic                  r_cfg_cnt;
  logic                  r_err_cnt;
  logic [RADDR_BITS-1:0] r_prx_addr;
  logic [31:0]           r_prx_wdata;

  logic                  w_accept;
  logic                  w_is_cfg;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wr_cfg;
  logic                  w_drop_cfg;
  logic [1:0]            w_count_next;

  assign w_accept     = pkt_vld_in && r_rdy;
  assign w_is_cfg     = ((pkt_key_in & CFG_MSK) == CFG_KEY);
  assign w_push       = w_accept && !w_is_cfg;
  assign w_pop        = (r_count != 2'd0) && out_rdy_in;
  assign w_wr_cfg     = w_accept && w_is_cfg && pkt_pld_in;
  assign w_drop_cfg   = w_accept && w_is_cfg && !pkt_pld_in;
  // push and pop together leave occupancy unchanged
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // FIFO occupancy, pointers and registered ready (next occupancy < 2)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_rdy    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_next;
      r_rdy   <= (w_count_next < 2'd2);
    end
  end

  // FIFO entry storage; cleared by reset so out_* read zero while in reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        r_ent_key[i]  <= 32'd0;
        r_ent_data[i] <= 32'd0;
        r_ent_pld[i]  <= 1'b0;
      end
    end else if (w_push) begin
      r_ent_key[r_wr_ptr]  <= pkt_key_in;
      r_ent_data[r_wr_ptr] <= pkt_data_in;
      r_ent_pld[r_wr_ptr]  <= pkt_pld_in;
    end
  end

  // config path: one-cycle write strobe and counter pulses, address/data hold
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prx_en    <= 1'b0;
      r_cfg_cnt   <= 1'b0;
      r_err_cnt   <= 1'b0;
      r_prx_addr  <= '0;
      r_prx_wdata <= 32'd0;
    end else begin
      r_prx_en  <= w_wr_cfg;
      r_cfg_cnt <= w_wr_cfg;
      r_err_cnt <= w_drop_cfg;
      if (w_wr_cfg) begin
        r_prx_addr  <= pkt_key_in[RADDR_BITS-1:0];
        r_prx_wdata <= pkt_data_in;
      end
    end
  end

  assign pkt_rdy_out   = r_rdy;
  assign out_vld_out   = (r_count != 2'd0);
  assign out_key_out   = r_ent_key[r_rd_ptr];
  assign out_data_out  = r_ent_data[r_rd_ptr];
  assign out_pld_out   = r_ent_pld[r_rd_ptr];
  assign prx_en_out    = r_prx_en;
  assign cfg_cnt_out   = r_cfg_cnt;
  assign err_cnt_out   = r_err_cnt;
  assign prx_addr_out  = r_prx_addr;
  assign prx_wdata_out = r_prx_wdata;

endmodule

// File: doc/hssl_cfg_pkt_rx.md
HSSL_CFG_PKT_RX -- requirements
Module: hssl_cfg_pkt_rx

Interface
REQ-001 Parameter RADDR_BITS, default 8: width of register word address (4-bit section, 4-bit register).
REQ-002 Parameter CFG_KEY, default 32'hffff_fe00: routing key identifying configuration packets.
REQ-003 Parameter CFG_MSK, default 32'hffff_ff00: mask applied to the packet key before comparison with CFG_KEY.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 pkt_key_in  input  32  incoming packet routing key.
REQ-007 pkt_data_in  input  32  incoming packet payload.
REQ-008 pkt_pld_in  input  1  payload present.
REQ-009 pkt_vld_in  input  1  incoming packet valid.
REQ-010 pkt_rdy_out  output  1  incoming packet ready; registered.
REQ-011 out_key_out, out_data_out  output  32 each  forwarded packet key and payload.
REQ-012 out_pld_out  output  1  forwarded payload present.
REQ-013 out_vld_out  output  1  forwarded packet valid.
REQ-014 out_rdy_in  input  1  downstream ready.
REQ-015 prx_addr_out  output  RADDR_BITS  register-bank write address.
REQ-016 prx_wdata_out  output  32  register-bank write data.
REQ-017 prx_en_out  output  1  register-bank write strobe, one cycle per write.
REQ-018 cfg_cnt_out, err_cnt_out  output  1 each  single-cycle pulses to diagnostic counter enables.

Function
REQ-019 Input handshake SHALL complete on a rising edge where pkt_vld_in && pkt_rdy_out.
REQ-020 A packet is a config packet when (pkt_key_in & CFG_MSK) == CFG_KEY; all other packets are forward packets.
REQ-021 On acceptance of a config packet with pkt_pld_in=1, the block SHALL, in the following cycle, drive prx_en_out=1, prx_addr_out=pkt_key_in[RADDR_BITS-1:0], prx_wdata_out=pkt_data_in, and cfg_cnt_out=1.
REQ-022 On acceptance of a config packet with pkt_pld_in=0, the block SHALL drop it, pulse err_cnt_out=1 the following cycle, and leave prx_en_out=0.
REQ-023 prx_en_out, cfg_cnt_out and err_cnt_out SHALL be 0 in every cycle not named in REQ-021/REQ-022; prx_addr_out and prx_wdata_out hold their last value.
REQ-024 Config packets SHALL bypass the forward buffer, with one write issued per accepted config packet, back to back at full rate.
REQ-025 Forward packets SHALL enter a 2-entry in-order FIFO (head plus skid); out_* SHALL present the head entry, unmodified.
REQ-026 out_vld_out = FIFO non-empty; the head is popped on a rising edge with out_vld_out && out_rdy_in.
REQ-027 pkt_rdy_out SHALL be registered, computed each cycle as next-cycle FIFO occupancy < 2, independent of packet type.
REQ-028 A simultaneous push and pop SHALL keep occupancy unchanged, with no bubble; a full FIFO with out_rdy_in=1 SHALL raise pkt_rdy_out on the next cycle.
REQ-029 Write latency: input handshake at edge N -> prx_en_out high during cycle N+1. Forward latency: handshake at edge N -> out_vld_out high during cycle N+1 when the FIFO was empty.
REQ-030 Config writes MAY overtake forward packets already buffered; forward packets SHALL never be reordered among themselves.
REQ-031 out_vld_out SHALL NOT deassert, and out_* SHALL NOT change, while out_vld_out=1 and out_rdy_in=0.

Reset
REQ-032 While resetn=0: pkt_rdy_out=0, out_vld_out=0, FIFO empty, prx_en_out=0, cfg_cnt_out=0, err_cnt_out=0, prx_addr_out=0, prx_wdata_out=0, out_key_out/out_data_out/out_pld_out=0.
REQ-033 pkt_rdy_out SHALL rise in the first cycle after resetn deasserts.
REQ-034 Reset asserted mid-operation SHALL discard buffered packets and any pending write strobe, with no prx_en_out pulse emitted after reset.

Verification
REQ-035 Config write: key 32'hffff_fe23, data 32'h0000_0001, pld=1 -> next cycle prx_en_out=1, prx_addr_out=8'h23, prx_wdata_out=1, cfg_cnt_out=1, out_vld_out=0.
REQ-036 Missing payload: key 32'hffff_fe10, pld=0 -> err_cnt_out pulse, no prx_en_out, no forwarded packet.
REQ-037 Backpressure: out_rdy_in=0, send forward keys 0x100, 0x101, 0x102 -> two accepted, pkt_rdy_out=0, out_key_out holds 0x100; raise out_rdy_in -> 0x100, 0x101, 0x102 emerge in order.
REQ-038 Bypass: FIFO full and out_rdy_in=0 -> no config packet accepted; pop one entry, then send config key 32'hffff_fe05 -> write issued while 0x101 is still buffered.
REQ-039 Throughput: 16 alternating forward/config packets with out_rdy_in=1 -> pkt_rdy_out stays 1, 8 writes, 8 forwarded packets.
REQ-040 Reset mid-stream: assert resetn=0 with the FIFO holding 2 entries -> out_vld_out=0 immediately, with no residual packets or writes after release.
